// File: rtl/serial_delay.sv
// Fixed-depth shift pipeline for the read-data nibble stream.
// It advances only on enabled edges and clears to zero on reset.
module serial_delay #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (enable) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/serial_ram_rw.sv
// Nibble-serial RAM port. Each frame assembles an address and write word, one nibble per slot.
// The addressed word is read back serially in the next frame, through a DELAY-stage output pipeline.
module serial_ram_rw #(
    parameter int ADDR_PINS     = 4,
    parameter int DATA_PINS     = 4,
    parameter int LOG2_CYCLES   = 2,
    parameter int RAM_ADDR_BITS = 12,
    parameter int DELAY         = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ADDR_PINS-1:0] addr_in,
    input  logic [DATA_PINS-1:0] data_in,
    input  logic                 we_in,
    output logic [DATA_PINS-1:0] data_out,
    output logic                 frame_sync
);

    localparam int CYCLES    = 2**LOG2_CYCLES;
    localparam int ADDR_BITS = ADDR_PINS * CYCLES;
    localparam int DATA_BITS = DATA_PINS * CYCLES;

    logic [LOG2_CYCLES-1:0] slot;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [ADDR_BITS-1:0]   addr_live;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS-1:0]   data_live;
    logic [DATA_BITS-1:0]   rd_q;
    logic [DATA_BITS-1:0]   mem [2**RAM_ADDR_BITS];
    logic                   last_slot;
    logic                   unused_bits;

    assign last_slot  = (slot == '1);
    assign frame_sync = (slot == '0);

    // The final nibble is still on the pins during the last slot, so the write uses it live.
    assign addr_live = {addr_in, addr_q[ADDR_BITS-ADDR_PINS-1:0]};
    assign data_live = {data_in, data_q[DATA_BITS-DATA_PINS-1:0]};

    // Address bits above RAM_ADDR_BITS and the stored top data nibble are never consumed.
    assign unused_bits = ^{addr_q, addr_live, data_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= '0;
            addr_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
        end else if (enable) begin
            slot <= slot + 1'b1;
            addr_q[slot*ADDR_PINS +: ADDR_PINS] <= addr_in;
            data_q[slot*DATA_PINS +: DATA_PINS] <= data_in;
            if (slot == '0) begin
                rd_q <= mem[addr_q[RAM_ADDR_BITS-1:0]];
            end else begin
                rd_q <= rd_q >> DATA_PINS;
            end
        end
    end

    // Slot is held at 0 during reset, so a reset mid-frame never writes.
    always_ff @(posedge clk) begin
        if (enable && last_slot && we_in) begin
            mem[addr_live[RAM_ADDR_BITS-1:0]] <= data_live;
        end
    end

    serial_delay #(
        .WIDTH (DATA_PINS),
        .DEPTH (DELAY)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .d      (rd_q[DATA_PINS-1:0]),
        .q      (data_out)
    );

endmodule
